// File: rtl/instr_fetch_if.sv
// Instruction memory read bus between the fetch stage and instruction memory.
//   mem_req   : read request, held until mem_ack
//   mem_addr  : word address of the outstanding read
//   mem_rdata : read data, valid when mem_req && mem_ack
//   mem_ack   : read complete
// The master modport belongs to the fetch stage; the slave modport belongs to memory.
interface instr_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
  modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding the control unit.
// It reads words from instruction memory one at a time and buffers them in a
// small prefetch FIFO. The head entry is presented to control together with
// its address. A redirect flushes the FIFO and discards any read in flight.
//
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous, active-high
//   mem         : instruction memory bus (master side)
//   redirect    : taken-branch pulse
//   redirect_pc : new fetch address, sampled with redirect
//   ir_take     : control consumes the head word
//   IR, ir_pc   : head instruction and its word address
//   ir_valid    : FIFO not empty
//
// state  | meaning
// S_IDLE | no read outstanding
// S_WAIT | read outstanding; data is pushed on ack
// S_DROP | read outstanding after a redirect; data is discarded on ack
module instr_fetch #(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master mem,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          ir_take,
  output logic [31:0]   IR,
  output logic [31:0]   ir_pc,
  output logic          ir_valid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   faddr;
  logic [31:0]   addr_q;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic          issue, push, pop;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!redirect && (count < DEPTH_C)) begin
          state_nxt = S_WAIT;
          issue     = 1'b1;
        end
      end
      S_WAIT: begin
        // A redirect coinciding with the ack turns the ack into a discard.
        if (mem.mem_ack) begin
          state_nxt = S_IDLE;
          push      = !redirect;
        end else if (redirect) begin
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (mem.mem_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign pop = ir_take && (count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      addr_q <= '0;
    else if (issue) addr_q <= faddr;
  end

  // faddr only advances on a kept word, so a dropped read never skips an address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         faddr <= '0;
    else if (redirect) faddr <= redirect_pc;
    else if (push)     faddr <= faddr + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (redirect) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc_mem[wptr]    <= addr_q;
        instr_mem[wptr] <= mem.mem_rdata;
        wptr            <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign mem.mem_req  = (state != S_IDLE);
  assign mem.mem_addr = addr_q;
  assign IR           = instr_mem[rptr];
  assign ir_pc        = pc_mem[rptr];
  assign ir_valid     = (count != '0);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ir_take;
  logic [31:0] IR;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        auto_ack;
  logic        man_ack;
  int          checks = 0;
  int          errors = 0;

  instr_fetch_if mem ();

  // Memory model: data = address + 0x100; ack is zero-wait or manual.
  assign mem.mem_rdata = mem.mem_addr + 32'h100;
  assign mem.mem_ack   = auto_ack ? mem.mem_req : man_ack;

  instr_fetch #(.DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (mem.master),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .ir_take    (ir_take),
    .IR         (IR),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    ir_take     = 1'b0;
    auto_ack    = 1'b1;
    man_ack     = 1'b0;
    tick();
    tick();
    chk("rst_req",   {31'd0, mem.mem_req}, 32'd0);
    chk("rst_addr",  mem.mem_addr, 32'd0);
    chk("rst_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_ir",    IR, 32'd0);
    chk("rst_pc",    ir_pc, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fill the FIFO with zero-wait memory.
    tick();
    chk("f1_req",  {31'd0, mem.mem_req}, 32'd1);
    chk("f1_addr", mem.mem_addr, 32'd0);
    tick();
    chk("f1_valid", {31'd0, ir_valid}, 32'd1);
    chk("f1_ir",    IR, 32'h100);
    chk("f1_pc",    ir_pc, 32'd0);
    chk("f1_req0",  {31'd0, mem.mem_req}, 32'd0);
    tick();
    chk("f2_req",  {31'd0, mem.mem_req}, 32'd1);
    chk("f2_addr", mem.mem_addr, 32'd1);
    tick();
    chk("full_req_a", {31'd0, mem.mem_req}, 32'd0);
    tick();
    chk("full_req_b", {31'd0, mem.mem_req}, 32'd0);
    chk("full_ir",    IR, 32'h100);

    // Pop one word from a full FIFO.
    ir_take = 1'b1;
    tick();
    ir_take = 1'b0;
    chk("pop_ir",  IR, 32'h101);
    chk("pop_pc",  ir_pc, 32'd1);
    chk("pop_req", {31'd0, mem.mem_req}, 32'd0);
    tick();
    chk("refill_req",  {31'd0, mem.mem_req}, 32'd1);
    chk("refill_addr", mem.mem_addr, 32'd2);

    // Redirect while waiting on a slow read.
    auto_ack = 1'b0;
    tick();
    chk("slow_req", {31'd0, mem.mem_req}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk("drop_valid", {31'd0, ir_valid}, 32'd0);
    chk("drop_req",   {31'd0, mem.mem_req}, 32'd1);
    chk("drop_addr",  mem.mem_addr, 32'd2);
    tick();
    chk("drop_hold", mem.mem_addr, 32'd2);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("drop_done_req",   {31'd0, mem.mem_req}, 32'd0);
    chk("drop_done_valid", {31'd0, ir_valid}, 32'd0);
    tick();
    chk("redir_req",  {31'd0, mem.mem_req}, 32'd1);
    chk("redir_addr", mem.mem_addr, 32'h40);
    auto_ack = 1'b1;
    tick();
    chk("redir_valid", {31'd0, ir_valid}, 32'd1);
    chk("redir_ir",    IR, 32'h140);
    chk("redir_pc",    ir_pc, 32'h40);

    // One entry buffered: push and pop in the same cycle.
    tick();
    chk("pp_addr", mem.mem_addr, 32'h41);
    ir_take = 1'b1;
    tick();
    ir_take = 1'b0;
    chk("pp_ir",    IR, 32'h141);
    chk("pp_pc",    ir_pc, 32'h41);
    chk("pp_valid", {31'd0, ir_valid}, 32'd1);
    tick();
    chk("pp_next_req",  {31'd0, mem.mem_req}, 32'd1);
    chk("pp_next_addr", mem.mem_addr, 32'h42);

    // Redirect coinciding with an ack, to the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    chk("wrap_flush", {31'd0, ir_valid}, 32'd0);
    chk("wrap_req0",  {31'd0, mem.mem_req}, 32'd0);
    tick();
    chk("wrap_addr_a", mem.mem_addr, 32'hFFFF_FFFF);
    tick();
    chk("wrap_ir",  IR, 32'h0000_00FF);
    chk("wrap_pc",  ir_pc, 32'hFFFF_FFFF);
    tick();
    chk("wrap_addr_b", mem.mem_addr, 32'h0);
    chk("wrap_req1",   {31'd0, mem.mem_req}, 32'd1);
    tick();
    chk("wrap_full_req", {31'd0, mem.mem_req}, 32'd0);

    // Async reset in the middle of a read with a word buffered.
    ir_take = 1'b1;
    tick();
    ir_take  = 1'b0;
    auto_ack = 1'b0;
    chk("pre_rst_ir", IR, 32'h100);
    chk("pre_rst_pc", ir_pc, 32'h0);
    tick();
    chk("pre_rst_req",  {31'd0, mem.mem_req}, 32'd1);
    chk("pre_rst_addr", mem.mem_addr, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_req",   {31'd0, mem.mem_req}, 32'd0);
    chk("arst_valid", {31'd0, ir_valid}, 32'd0);
    chk("arst_ir",    IR, 32'd0);
    chk("arst_addr",  mem.mem_addr, 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    auto_ack = 1'b1;
    tick();
    chk("resume_req",  {31'd0, mem.mem_req}, 32'd1);
    chk("resume_addr", mem.mem_addr, 32'd0);
    tick();
    chk("resume_ir", IR, 32'h100);
    chk("resume_pc", ir_pc, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
